// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared declarations for the simple-dual-port memory:
//   clr_state_e : clear-engine states (ST_IDLE, ST_CLEAR)
//   word_t/be_t : widest supported word and byte-enable vectors
//   merge_be()  : byte-enable merge of a new word over an old word
// -----------------------------------------------------------------------------
package mem_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_e;

   // merge_be works on the widest supported word; callers cast in and out,
   // so a single function serves every DATA_W instance.
   localparam int MAX_DATA_W = 256;
   localparam int MAX_BE_W   = MAX_DATA_W / 8;

   typedef logic [MAX_DATA_W-1:0] word_t;
   typedef logic [MAX_BE_W-1:0]   be_t;

   // Enabled bytes come from new_w, all other bytes keep old_w.
   function automatic word_t merge_be(input word_t old_w,
                                      input word_t new_w,
                                      input be_t   be);
      word_t res;
      res = old_w;
      for (int i = 0; i < MAX_BE_W; i++) begin
         if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/mem_clear_fsm.sv
// -----------------------------------------------------------------------------
// mem_clear_fsm
// Clear engine: on clr_req in IDLE it sweeps addresses 0..DEPTH-1, one per
// cycle, then pulses clr_done. Requests while running are ignored.
// Ports:
//   clk        in   clock, posedge
//   rst        in   asynchronous active-low reset
//   clr_req    in   start request, sampled only in ST_IDLE
//   busy       out  1 while sweeping
//   clr_done   out  1-cycle pulse after the last address is written
//   clr_wr_en  out  write strobe for the array
//   clr_addr   out  address being cleared this cycle
// -----------------------------------------------------------------------------
module mem_clear_fsm
   import mem_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_req,
   output logic              busy,
   output logic              clr_done,
   output logic              clr_wr_en,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q,   cnt_d;
   logic              done_q,  done_d;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of process order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // NOTE: every variable gets a default before the case so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (clr_req) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         ST_CLEAR: begin
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy      = (state_q == ST_CLEAR);
   assign clr_wr_en = busy;
   assign clr_addr  = cnt_q;
   assign clr_done  = done_q;

endmodule

// File: rtl/mem_dp_param.sv
// -----------------------------------------------------------------------------
// mem_dp_param
// Simple-dual-port synchronous memory with byte-enabled write port, registered
// read port (write-first on same-address collision) and a built-in clear
// engine that fills the array with CLEAR_VAL.
// Ports:
//   clk       in   clock, posedge
//   rst       in   asynchronous active-low reset
//   wr_en     in   write request
//   wr_addr   in   write address
//   wr_be     in   byte enables, bit i covers wr_data[8i+7:8i]
//   wr_data   in   write data
//   rd_en     in   read request
//   rd_addr   in   read address
//   rd_data   out  read data, qualified by rd_valid, held otherwise
//   rd_valid  out  1-cycle pulse one cycle after an accepted read
//   clr_req   in   start clear (sampled only while idle)
//   busy      out  1 while the clear engine runs; user accesses ignored
//   clr_done  out  1-cycle pulse after the last word is cleared
// -----------------------------------------------------------------------------
module mem_dp_param
   import mem_pkg::*;
#(
   parameter int                DATA_W    = 32,
   parameter int                ADDR_W    = 5,
   parameter int                DEPTH     = 2**ADDR_W,
   parameter string             INIT_FILE = "mem.hex",
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W/8-1:0] wr_be,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic                rd_en,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [DATA_W-1:0]   rd_data,
   output logic                rd_valid,
   input  logic                clr_req,
   output logic                busy,
   output logic                clr_done
);

   localparam int BE_W = DATA_W / 8;

   // DEPTH widened by one bit so the range compare works even when
   // DEPTH == 2**ADDR_W.
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic              clr_wr_en;
   logic [ADDR_W-1:0] clr_addr;

   logic              wr_in_range, rd_in_range;
   logic              wr_accept,   rd_accept;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [BE_W-1:0]   mem_be;
   logic [DATA_W-1:0] mem_wdata;

   logic [DATA_W-1:0] bypass_word;
   logic [DATA_W-1:0] rd_data_d, rd_data_q;
   logic              rd_valid_q;

   mem_clear_fsm #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_clear_fsm (
      .clk       (clk),
      .rst       (rst),
      .clr_req   (clr_req),
      .busy      (busy),
      .clr_done  (clr_done),
      .clr_wr_en (clr_wr_en),
      .clr_addr  (clr_addr)
   );

   assign wr_in_range = ({1'b0, wr_addr} < DEPTH_X);
   assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);
   assign wr_accept   = wr_en && !busy && wr_in_range;
   assign rd_accept   = rd_en && !busy;

   // Write mux: the clear engine owns the port while it runs. User accesses
   // are gated by busy anyway, so the two sources never collide.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = wr_addr;
      mem_be    = wr_be;
      mem_wdata = wr_data;
      if (clr_wr_en) begin
         mem_we    = 1'b1;
         mem_waddr = clr_addr;
         mem_be    = '1;
         mem_wdata = CLEAR_VAL;
      end else begin
         mem_we    = wr_accept;
      end
   end

   // NOTE: the array has no reset; contents survive rst and are only changed
   // by writes or the clear engine, which keeps it mappable onto
   // block/distributed RAM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < BE_W; b++) begin
            if (mem_be[b]) mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
   end

   // Write-first bypass: a same-address read sees the stored word with the
   // enabled bytes replaced by this cycle's write data.
   assign bypass_word = DATA_W'(merge_be(word_t'(mem[rd_addr]),
                                         word_t'(wr_data),
                                         be_t'(wr_be)));

   always_comb begin
      rd_data_d = mem[rd_addr];
      if (!rd_in_range) begin
         rd_data_d = '0;
      end else if (wr_accept && (wr_addr == rd_addr)) begin
         rd_data_d = bypass_word;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_accept;
         if (rd_accept) rd_data_q <= rd_data_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

endmodule
